// File: rtl/ledpanel_loader.sv
// rtl/ledpanel_loader.sv - rectangular-window pixel writer for the LED panel video memory
//
// Accepts a window command (corners in any order) and then either assembles
// host bytes into 24-bit pixels (stream mode) or writes a constant colour
// (fill mode), walking the window in raster order: x fastest, then y.
//
// Parameters:
//   BGR_ORDER  0: stream bytes arrive R,G,B   1: B,G,R   (output is always {R,G,B})
//   FILL_GAP   idle cycles between consecutive fill writes (0..15)
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           window command handshake
//   cmd_mode                      0 = stream, 1 = fill
//   cmd_x0/y0/x1/y1               window corners (5 bits each)
//   cmd_rgb                       fill colour {R,G,B}
//   in_valid/in_ready/in_data     stream byte handshake
//   abort                         synchronous abort of the current command
//   wr_enable/wr_addr_x/y/rgb     pixel write port to video memory
//   busy                          command in progress
//   done                          one-cycle pulse after the last pixel write

module ledpanel_loader #(
  parameter bit          BGR_ORDER = 1'b0,
  parameter int unsigned FILL_GAP  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [4:0]  cmd_x0,
  input  logic [4:0]  cmd_y0,
  input  logic [4:0]  cmd_x1,
  input  logic [4:0]  cmd_y1,
  input  logic [23:0] cmd_rgb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        abort,
  output logic        wr_enable,
  output logic [4:0]  wr_addr_x,
  output logic [4:0]  wr_addr_y,
  output logic [23:0] wr_rgb_data,
  output logic        busy,
  output logic        done
);

  // LAST covers the cycle in which the final write is on the port: still busy,
  // but no more bytes or fill writes may be taken.
  typedef enum logic [1:0] {IDLE, STREAM, FILL, LAST} state_t;

  localparam logic [3:0] GAP = 4'(FILL_GAP);

  state_t      state, state_n;
  logic [4:0]  xmin, xmin_n, xmax, xmax_n, ymax, ymax_n;
  logic [4:0]  cur_x, cur_x_n, cur_y, cur_y_n;
  logic [1:0]  phase, phase_n;
  logic [7:0]  byte0, byte0_n, byte1, byte1_n;
  logic [3:0]  gap_cnt, gap_n;
  logic [23:0] fill_rgb, fill_rgb_n;
  logic        wr_enable_n, done_n;
  logic [4:0]  wr_x_n, wr_y_n;
  logic [23:0] wr_rgb_n;

  logic        cmd_fire, in_fire, at_last;
  logic [4:0]  c_xmin, c_xmax, c_ymin, c_ymax;
  logic [23:0] stream_rgb;

  assign cmd_ready = (state == IDLE) && !reset;
  assign in_ready  = (state == STREAM) && !abort;
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;

  assign c_xmin = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
  assign c_xmax = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
  assign c_ymin = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
  assign c_ymax = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;

  // The cursor always names the next pixel to be written.
  assign at_last = (cur_x == xmax) && (cur_y == ymax);

  // in_data is the third byte of the triplet when this is used.
  assign stream_rgb = BGR_ORDER ? {in_data, byte1, byte0} : {byte0, byte1, in_data};

  // Raster step; never called on the final pixel, so y cannot run past ymax.
  function automatic logic [9:0] step_cursor(input logic [4:0] x, input logic [4:0] y,
                                             input logic [4:0] lo, input logic [4:0] hi);
    if (x == hi) return {lo, y + 5'd1};
    return {x + 5'd1, y};
  endfunction

  always_comb begin
    state_n     = state;
    xmin_n      = xmin;
    xmax_n      = xmax;
    ymax_n      = ymax;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    phase_n     = phase;
    byte0_n     = byte0;
    byte1_n     = byte1;
    gap_n       = gap_cnt;
    fill_rgb_n  = fill_rgb;
    wr_enable_n = 1'b0;
    wr_x_n      = wr_addr_x;
    wr_y_n      = wr_addr_y;
    wr_rgb_n    = wr_rgb_data;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        // abort is ignored here; a coincident command is still taken.
        if (cmd_fire) begin
          xmin_n     = c_xmin;
          xmax_n     = c_xmax;
          ymax_n     = c_ymax;
          phase_n    = 2'd0;
          fill_rgb_n = cmd_rgb;
          if (cmd_mode) begin
            // First fill pixel goes out on the very next cycle.
            wr_enable_n = 1'b1;
            wr_x_n      = c_xmin;
            wr_y_n      = c_ymin;
            wr_rgb_n    = cmd_rgb;
            gap_n       = GAP;
            if ((c_xmin == c_xmax) && (c_ymin == c_ymax)) begin
              state_n = LAST;
            end else begin
              {cur_x_n, cur_y_n} = step_cursor(c_xmin, c_ymin, c_xmin, c_xmax);
              state_n = FILL;
            end
          end else begin
            cur_x_n = c_xmin;
            cur_y_n = c_ymin;
            state_n = STREAM;
          end
        end
      end

      STREAM: begin
        if (abort) begin
          state_n = IDLE;
          phase_n = 2'd0;
        end else if (in_fire) begin
          unique case (phase)
            2'd0: begin
              byte0_n = in_data;
              phase_n = 2'd1;
            end
            2'd1: begin
              byte1_n = in_data;
              phase_n = 2'd2;
            end
            default: begin
              phase_n     = 2'd0;
              wr_enable_n = 1'b1;
              wr_x_n      = cur_x;
              wr_y_n      = cur_y;
              wr_rgb_n    = stream_rgb;
              if (at_last) state_n = LAST;
              else {cur_x_n, cur_y_n} = step_cursor(cur_x, cur_y, xmin, xmax);
            end
          endcase
        end
      end

      FILL: begin
        if (abort) begin
          state_n = IDLE;
        end else if (gap_cnt == 4'd0) begin
          wr_enable_n = 1'b1;
          wr_x_n      = cur_x;
          wr_y_n      = cur_y;
          wr_rgb_n    = fill_rgb;
          gap_n       = GAP;
          if (at_last) state_n = LAST;
          else {cur_x_n, cur_y_n} = step_cursor(cur_x, cur_y, xmin, xmax);
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end

      LAST: begin
        state_n = IDLE;
        done_n  = !abort;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      xmin        <= 5'd0;
      xmax        <= 5'd0;
      ymax        <= 5'd0;
      cur_x       <= 5'd0;
      cur_y       <= 5'd0;
      phase       <= 2'd0;
      byte0       <= 8'd0;
      byte1       <= 8'd0;
      gap_cnt     <= 4'd0;
      fill_rgb    <= 24'd0;
      wr_enable   <= 1'b0;
      wr_addr_x   <= 5'd0;
      wr_addr_y   <= 5'd0;
      wr_rgb_data <= 24'd0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      xmin        <= xmin_n;
      xmax        <= xmax_n;
      ymax        <= ymax_n;
      cur_x       <= cur_x_n;
      cur_y       <= cur_y_n;
      phase       <= phase_n;
      byte0       <= byte0_n;
      byte1       <= byte1_n;
      gap_cnt     <= gap_n;
      fill_rgb    <= fill_rgb_n;
      wr_enable   <= wr_enable_n;
      wr_addr_x   <= wr_x_n;
      wr_addr_y   <= wr_y_n;
      wr_rgb_data <= wr_rgb_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_ledpanel_loader.sv
// tb/tb_ledpanel_loader.sv - scoreboard bench for ledpanel_loader (two parameter sets)

module tb_ledpanel_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel, cmd_valid, cmd_mode, in_valid, abort;
  logic [4:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [23:0] cmd_rgb;
  logic [7:0]  in_data;

  logic        a_cmd_ready, a_in_ready, a_wr_enable, a_busy, a_done;
  logic [4:0]  a_wr_x, a_wr_y;
  logic [23:0] a_wr_rgb;
  logic        b_cmd_ready, b_in_ready, b_wr_enable, b_busy, b_done;
  logic [4:0]  b_wr_x, b_wr_y;
  logic [23:0] b_wr_rgb;

  ledpanel_loader #(.BGR_ORDER(1'b0), .FILL_GAP(0)) u_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
    .cmd_mode(cmd_mode), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_rgb(cmd_rgb), .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data),
    .abort(abort && !sel), .wr_enable(a_wr_enable), .wr_addr_x(a_wr_x), .wr_addr_y(a_wr_y),
    .wr_rgb_data(a_wr_rgb), .busy(a_busy), .done(a_done)
  );

  ledpanel_loader #(.BGR_ORDER(1'b1), .FILL_GAP(2)) u_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
    .cmd_mode(cmd_mode), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_rgb(cmd_rgb), .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data),
    .abort(abort && sel), .wr_enable(b_wr_enable), .wr_addr_x(b_wr_x), .wr_addr_y(b_wr_y),
    .wr_rgb_data(b_wr_rgb), .busy(b_busy), .done(b_done)
  );

  logic        s_cmd_ready, s_in_ready, s_wr_enable, s_busy, s_done;
  logic [4:0]  s_wr_x, s_wr_y;
  logic [23:0] s_wr_rgb;
  assign s_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign s_wr_enable = sel ? b_wr_enable : a_wr_enable;
  assign s_busy      = sel ? b_busy      : a_busy;
  assign s_done      = sel ? b_done      : a_done;
  assign s_wr_x      = sel ? b_wr_x      : a_wr_x;
  assign s_wr_y      = sel ? b_wr_y      : a_wr_y;
  assign s_wr_rgb    = sel ? b_wr_rgb    : a_wr_rgb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [23:0] rgb;
    int          cyc;
  } wr_t;

  typedef struct {
    bit          mode;
    logic [4:0]  x0, y0, x1, y1;
    logic [23:0] rgb;
    logic [7:0]  seed;
    int          exp_pix;
  } vec_t;

  wr_t        exp_q[$];
  int         done_q[$];
  logic [9:0] coord_q[$];
  int total = 0, bad = 0, wr_count = 0, busy_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic monitor();
    wr_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (s_busy) busy_count++;
        if (s_wr_enable) begin
          wr_count++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected: got (%0d,%0d)=%06h @%0d required no write",
                     s_wr_x, s_wr_y, s_wr_rgb, cyc);
          end else begin
            e = exp_q.pop_front();
            if (s_wr_x !== e.x || s_wr_y !== e.y || s_wr_rgb !== e.rgb || cyc != e.cyc) begin
              bad++;
              $display("FAIL wr_pixel: got (%0d,%0d)=%06h @%0d required (%0d,%0d)=%06h @%0d",
                       s_wr_x, s_wr_y, s_wr_rgb, cyc, e.x, e.y, e.rgb, e.cyc);
            end
          end
        end
        if (s_done) begin
          total++;
          if (done_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: got done @%0d required none", cyc);
          end else begin
            d = done_q.pop_front();
            if (d != cyc) begin
              bad++;
              $display("FAIL done_cycle: got @%0d required @%0d", cyc, d);
            end
          end
        end
      end
    end
  endtask

  task automatic build_coords(input logic [4:0] x0, input logic [4:0] y0,
                              input logic [4:0] x1, input logic [4:0] y1);
    int xl, xh, yl, yh;
    xl = (x0 < x1) ? int'(x0) : int'(x1);
    xh = (x0 < x1) ? int'(x1) : int'(x0);
    yl = (y0 < y1) ? int'(y0) : int'(y1);
    yh = (y0 < y1) ? int'(y1) : int'(y0);
    coord_q.delete();
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        coord_q.push_back({5'(x), 5'(y)});
  endtask

  task automatic issue(input bit mode, input logic [4:0] x0, input logic [4:0] y0,
                       input logic [4:0] x1, input logic [4:0] y1,
                       input logic [23:0] rgb, output int acc);
    cmd_mode = mode; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_rgb = rgb;
    cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_now("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_fill(input logic [23:0] rgb, input int acc, input int gap);
    wr_t e;
    int  n;
    n = coord_q.size();
    for (int k = 0; k < n; k++) begin
      e.x = coord_q[k][9:5];
      e.y = coord_q[k][4:0];
      e.rgb = rgb;
      e.cyc = acc + 1 + k * (gap + 1);
      exp_q.push_back(e);
    end
    done_q.push_back(acc + 1 + (n - 1) * (gap + 1) + 1);
  endtask

  // Drives nbytes bytes seed, seed+step, ... and scores each completed triplet.
  task automatic send_stream(input logic [7:0] seed, input logic [7:0] step, input bit bgr,
                             input bit toggle, input int nbytes);
    logic [7:0] trip[3];
    logic [7:0] b;
    bit  ph, accepted;
    int  acc, pix;
    wr_t e;
    ph = !toggle;
    for (int k = 0; k < nbytes; k++) begin
      b = seed + 8'(k) * step;
      accepted = 1'b0;
      acc = 0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        in_valid = toggle ? ph : 1'b1;
        in_data  = in_valid ? b : 8'hEE;
        @(negedge clk);
        if (in_valid && s_in_ready) begin
          accepted = 1'b1;
          acc = cyc;
        end
        @(posedge clk); #1;
        ph = !ph;
      end
      if (!accepted) begin
        fail_now("byte_accept");
        break;
      end
      trip[k % 3] = b;
      if (k % 3 == 2) begin
        pix = k / 3;
        e.x = coord_q[pix][9:5];
        e.y = coord_q[pix][4:0];
        e.rgb = bgr ? {trip[2], trip[1], trip[0]} : {trip[0], trip[1], trip[2]};
        e.cyc = acc + 1;
        exp_q.push_back(e);
        if (pix == coord_q.size() - 1) done_q.push_back(acc + 2);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && !s_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[5];
    int   acc, acc2, snap_w, snap_b;
    bit   reached;

    vecs[0] = '{mode: 1'b0, x0: 5'd3,  y0: 5'd5,  x1: 5'd4,  y1: 5'd6,  rgb: 24'h0,      seed: 8'h11, exp_pix: 4};
    vecs[1] = '{mode: 1'b1, x0: 5'd31, y0: 5'd31, x1: 5'd0,  y1: 5'd0,  rgb: 24'hFF0080, seed: 8'h00, exp_pix: 1024};
    vecs[2] = '{mode: 1'b1, x0: 5'd2,  y0: 5'd7,  x1: 5'd0,  y1: 5'd5,  rgb: 24'h123456, seed: 8'h00, exp_pix: 9};
    vecs[3] = '{mode: 1'b0, x0: 5'd10, y0: 5'd1,  x1: 5'd8,  y1: 5'd1,  rgb: 24'h0,      seed: 8'h05, exp_pix: 3};
    vecs[4] = '{mode: 1'b1, x0: 5'd20, y0: 5'd20, x1: 5'd20, y1: 5'd20, rgb: 24'hC0FFEE, seed: 8'h00, exp_pix: 1};

    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; in_valid = 1'b0; abort = 1'b0;
    cmd_x0 = 5'd0; cmd_y0 = 5'd0; cmd_x1 = 5'd0; cmd_y1 = 5'd0; cmd_rgb = 24'd0; in_data = 8'd0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    check("reset_outputs_a", 64'({a_wr_enable, a_done, a_busy, a_cmd_ready, a_in_ready, a_wr_x, a_wr_y, a_wr_rgb}), 64'd0);
    check("reset_outputs_b", 64'({b_wr_enable, b_done, b_busy, b_cmd_ready, b_in_ready, b_wr_x, b_wr_y, b_wr_rgb}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'({a_cmd_ready, b_cmd_ready}), 64'b11);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      snap_w = wr_count;
      snap_b = busy_count;
      build_coords(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      issue(vecs[i].mode, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].rgb, acc);
      if (vecs[i].mode) push_fill(vecs[i].rgb, acc, 0);
      else send_stream(vecs[i].seed, 8'h11, 1'b0, 1'b0, 3 * vecs[i].exp_pix);
      wait_idle("vec_idle");
      check("vec_write_count", 64'(wr_count - snap_w), 64'(vecs[i].exp_pix));
      if (vecs[i].mode) check("vec_fill_busy_cycles", 64'(busy_count - snap_b), 64'(vecs[i].exp_pix));
    end

    // Abort after one pixel plus one pending byte; the pending byte must be lost.
    snap_w = wr_count;
    build_coords(5'd0, 5'd0, 5'd1, 5'd0);
    issue(1'b0, 5'd0, 5'd0, 5'd1, 5'd0, 24'd0, acc);
    send_stream(8'h40, 8'h11, 1'b0, 1'b0, 4);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    check("abort_in_ready", 64'({s_in_ready, s_busy}), 64'b01);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'({s_busy, s_cmd_ready, s_done}), 64'b010);
    repeat (3) @(negedge clk);
    check("abort_write_count", 64'(wr_count - snap_w), 64'd1);
    check("abort_queue_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
    @(posedge clk); #1;
    build_coords(5'd9, 5'd9, 5'd9, 5'd9);
    issue(1'b0, 5'd9, 5'd9, 5'd9, 5'd9, 24'd0, acc);
    send_stream(8'h10, 8'h11, 1'b0, 1'b0, 3);
    wait_idle("post_abort_idle");
    check("post_abort_write_count", 64'(wr_count - snap_w), 64'd2);

    // Instance with BGR order and a fill gap of 2.
    sel = 1'b1;
    @(posedge clk); #1;
    snap_w = wr_count;
    build_coords(5'd7, 5'd9, 5'd7, 5'd9);
    issue(1'b1, 5'd7, 5'd9, 5'd7, 5'd9, 24'hABCDEF, acc);
    push_fill(24'hABCDEF, acc, 2);
    build_coords(5'd0, 5'd3, 5'd2, 5'd3);
    issue(1'b1, 5'd0, 5'd3, 5'd2, 5'd3, 24'h00FF00, acc2);
    check("b2b_accept_on_done", 64'(acc2), 64'(acc + 2));
    push_fill(24'h00FF00, acc2, 2);
    wait_idle("b2b_idle");
    check("b2b_write_count", 64'(wr_count - snap_w), 64'd4);

    snap_w = wr_count;
    build_coords(5'd5, 5'd12, 5'd5, 5'd12);
    issue(1'b0, 5'd5, 5'd12, 5'd5, 5'd12, 24'd0, acc);
    send_stream(8'h01, 8'h01, 1'b1, 1'b1, 3);
    wait_idle("toggle_idle");
    check("toggle_write_count", 64'(wr_count - snap_w), 64'd1);

    // Reset in the middle of a full-panel fill.
    sel = 1'b0;
    @(posedge clk); #1;
    snap_w = wr_count;
    build_coords(5'd31, 5'd31, 5'd0, 5'd0);
    issue(1'b1, 5'd31, 5'd31, 5'd0, 5'd0, 24'h5A5A5A, acc);
    push_fill(24'h5A5A5A, acc, 0);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_count - snap_w >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) fail_now("reset_ten_writes");
    #1 reset = 1'b1;
    #1;
    check("reset_async_outputs", 64'({a_wr_enable, a_done, a_busy, a_cmd_ready, a_wr_x, a_wr_y, a_wr_rgb}), 64'd0);
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_release_ready", 64'({a_cmd_ready, a_wr_enable, a_busy}), 64'b100);
    repeat (5) @(negedge clk);
    check("reset_write_count", 64'(wr_count - snap_w), 64'd10);

    check("queues_empty", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ledpanel_loader.md
Name: ledpanel_loader

Overview:
- Upstream pixel-write engine for the LED panel driver; generates its wr_enable / wr_addr_x / wr_addr_y / wr_rgb_data write port.
- Accepts a rectangular window command, then either streams host bytes (R,G,B triplets) into the window in raster order, or fills the window with a constant colour at one pixel per clock.
- Sits between the host byte interface (SPI/bus bridge) and the panel video memory.

Parameters:
- BGR_ORDER, 0, 0: stream bytes arrive R,G,B; 1: B,G,R. Output is always {R,G,B}.
- FILL_GAP, 0, idle cycles inserted between consecutive fill writes (0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_mode  in  1  0 = stream, 1 = fill
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  5 each  window corners, any order
- cmd_rgb  in  24  fill colour {R,G,B}
- in_valid  in  1  stream byte offered
- in_ready  out  1  stream byte accepted when in_valid && in_ready
- in_data  in  8  stream byte
- abort  in  1  synchronous abort of the current command
- wr_enable  out  1  pixel write strobe, one pixel per cycle high
- wr_addr_x, wr_addr_y  out  5 each  pixel coordinate
- wr_rgb_data  out  24  pixel colour {R,G,B}
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last pixel of a command

Behaviour:
- Reset (asynchronous): state IDLE; wr_enable, done = 0; wr_addr_x/y, wr_rgb_data = 0; byte phase = 0.
- cmd_ready = (state == IDLE) && !reset. in_ready = (state == STREAM) && !abort.
- On command accept, latch:
  - xmin = min(x0,x1), xmax = max(x0,x1); same for y.
  - Cursor = (xmin, ymin).
  - Next state is STREAM or FILL from cmd_mode.
- Raster order: x increments. At x == xmax, x returns to xmin and y increments. The write at (xmax, ymax) is the last. Pixel count = (xmax-xmin+1)*(ymax-ymin+1), range 1..1024. No 5-bit wraparound can occur.
- STREAM:
  - A 2-bit byte phase counts 0,1,2 over accepted bytes; bytes assemble into a 24-bit register.
  - On the accept of phase 2: wr_enable = 1 in the next cycle, with the cursor address and assembled colour. Cursor then advances.
  - Latency is 1 cycle from the third byte handshake to the write.
  - Max throughput is 1 pixel per 3 cycles. in_valid gaps stall without loss.
- FILL:
  - wr_enable high on the first cycle after accept, with wr_rgb_data = latched cmd_rgb.
  - Subsequent writes follow every (1+FILL_GAP) cycles. wr_enable is low during gap cycles.
- Completion:
  - The cycle after the last write, done = 1 and state = IDLE.
  - cmd_ready rises in that same cycle. A new command may be accepted there, giving back-to-back commands with 1 idle cycle.
- wr_addr_x/y and wr_rgb_data hold their last values while wr_enable = 0.
- abort, synchronous, while busy:
  - Next state is IDLE and any partial byte triplet is discarded.
  - A write already scheduled for this same cycle is still issued.
  - done is not pulsed. Bytes offered during the abort cycle are not accepted.
- abort in IDLE has no effect. If abort and cmd_valid occur together in IDLE, the command is accepted.
- Single-pixel window (x0==x1, y0==y1): exactly one write, then done.
- Reset mid-command: immediate IDLE. No further writes occur, and done is not pulsed.

Test Plan:
- Stream 2x2 window x0=3,y0=5,x1=4,y1=6, BGR_ORDER=0; bytes 11,22,33,44,55,66,77,88,99,AA,BB,CC with in_valid continuous -> writes (3,5)=112233, (4,5)=445566, (3,6)=778899, (4,6)=AABBCC. Each write follows its third-byte accept by exactly 1 cycle; done occurs 1 cycle after the last write.
- Fill with x0=31,y0=31,x1=0,y1=0 (reversed corners), cmd_rgb=FF0080, FILL_GAP=0 -> 1024 consecutive wr_enable cycles, first (0,0), last (31,31), all data FF0080; busy high for 1024 cycles, then done.
- Fill 1x1 at (7,9), FILL_GAP=2, followed immediately by a second fill 3x1 -> first command makes one write. The second command is accepted on the done cycle; its writes are spaced 3 cycles apart.
- Stream with abort after 4 bytes (one pixel written, one byte pending) -> exactly 1 write; IDLE next cycle; no done. A following stream command starts cleanly at byte phase 0.
- Stream with in_valid toggling every cycle and BGR_ORDER=1, bytes 01,02,03 -> single write of data 030201 at the cursor; no byte lost or duplicated.
- Assert reset mid-fill after 10 writes -> wr_enable=0 immediately (asynchronous); outputs zero; cmd_ready=1 after reset release.
